i2s_tx: RTL and testbench
=========================

# i2s_tx

Serial audio transmitter at the output end of the synth's effect chain. It accepts one mono 16-bit sample per frame from the delay/mixer stage over a valid/ready handshake. It duplicates the sample into the left and right slots and serializes it to the audio codec as a standard I2S stream (BCLK, LRCLK, SDATA), generating both bit clocks from the system clock. It is the sample consumer that sets the audio frame rate for everything upstream.

## Interface
Parameters:
- BCLK_DIV, default 16: Clk cycles per BCLK half-period, legal range ≥ 1. One frame is 64·BCLK_DIV Clk cycles.

Ports:
- Clk  input  1  system clock; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  when low, the bit-clock divider and serializer freeze; the handshake stays live.
- sample_in  input  16  signed two's-complement mono sample.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  holding register can accept a sample.
- BCLK  output  1  serial bit clock to the codec.
- LRCLK  output  1  word select: 0 = left slot, 1 = right slot.
- SDATA  output  1  serial data, MSB first, changes on BCLK falling edges.
- frame_start  output  1  one-Clk pulse on the cycle a new frame is loaded.
- underrun  output  1  one-Clk pulse when a frame is loaded with no fresh sample.

## Operation
- **Divider:** counter runs 0..BCLK_DIV−1 while Enable is high. At terminal count it wraps to 0 and BCLK toggles. A "fall event" is a terminal-count cycle with BCLK = 1.
- **Bit counter:** bit_cnt (5 bits) increments mod 32 on each fall event. LRCLK is registered to bit_cnt[4] of the new count, so LRCLK changes on BCLK falling edges.
- **Shift register:** 32 bits; SDATA = shreg[31].
  - Fall event with new bit_cnt = 1 (load edge): shreg ← {S,S}.
  - Any other fall event: shreg shifts left by one, LSB filled with 0.
  - Result is the I2S one-bit delay: left MSB is driven one BCLK after LRCLK falls, and right LSB is driven during the bit_cnt = 0 slot.
- **Choice of S at the load edge:**
  - If hold_valid = 1: S = hold, then hold_valid ← 0, last ← hold.
  - If hold_valid = 0: S = last and underrun pulses.
  - frame_start pulses on every load edge.
- **Handshake:**
  - sample_ready = ~hold_valid, driven from a register with no combinational path from sample_valid.
  - Transfer occurs when sample_valid & sample_ready: hold ← sample_in, hold_valid ← 1.
  - Simultaneous transfer and load edge while hold is empty: the load uses last (underrun pulses) and the new sample waits for the next frame.
- **Enable low:** divider, BCLK, LRCLK, bit_cnt and shreg hold their values, and no load edges occur. Transfers into hold still complete.
- **Reset (any time, including mid-frame):** asynchronously sets BCLK = 0, LRCLK = 0, SDATA = 0, sample_ready = 1, frame_start = 0, underrun = 0. Also clears divider, bit_cnt, shreg, hold, hold_valid and last. A partially sent frame is discarded.

## Timing
- BCLK period is 2·BCLK_DIV Clk cycles; frame period is 64·BCLK_DIV Clk cycles.
- With Enable high from reset release, BCLK rises at Clk cycle BCLK_DIV. The first fall event, which is also the first load edge, occurs at cycle 2·BCLK_DIV.
- Load edges then repeat every 64·BCLK_DIV cycles.
- A sample accepted at least one cycle before a load edge is transmitted in that frame. Its MSB is on SDATA one Clk after the load edge; outputs are registered.
- Upstream may present at most one sample per frame without backpressure. Otherwise sample_ready stays low until the next load edge, with ready reasserting the cycle after it.

## Structure
- Shared package synth_audio_pkg: SAMPLE_W = 16, FRAME_BITS = 32, and the sample_t typedef (logic signed [15:0]). The delay and mixer blocks use the same package.
- One sub-module, bclk_gen: divider and BCLK toggle, emitting fall-event and rise-event strobes, gated by Enable.
- Serializer, bit counter and handshake live in i2s_tx.

## Test plan
- **Reset-release first frame (BCLK_DIV = 2):** reset then release; push 16'hA5C3 before cycle 4. Expect the first load edge at cycle 4 with frame_start = 1. Left slot must read A5C3 MSB first, starting one BCLK after LRCLK falls; right slot identical.
- **Underrun:** no sample supplied for frame 2 after frame 1 carried 16'h8001. Expect underrun = 1 at the load edge and frame 2 retransmits 8001 in both slots.
- **Backpressure:** hold sample_valid high with 16'h0001, then 16'h0002. Expect sample_ready low after the first transfer until one cycle after the next load edge, and frames carrying 0001 then 0002.
- **Simultaneous transfer and load edge with hold empty:** present 16'h7FFF exactly on the load-edge cycle. Expect underrun pulse, frame repeats the old sample, and 7FFF is sent the following frame.
- **Enable low for 37 cycles mid-frame:** BCLK, LRCLK and SDATA must be frozen. After Enable returns high, the remaining bits must continue without loss or duplication.
- **Reset mid-frame (bit_cnt = 9):** all outputs must go to their reset values immediately; after release the first load edge occurs at cycle 2·BCLK_DIV and transmits 16'h0000 with underrun pulsing.

Source files
------------

// File: rtl/synth_audio_pkg.sv
// Shared audio-path types and sizes.
// Used by the delay, mixer and I2S transmitter blocks.
package synth_audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int BITCNT_W   = $clog2(FRAME_BITS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [FRAME_BITS-1:0]      frame_t;
  typedef logic [BITCNT_W-1:0]        bitcnt_t;

  // Mono sample duplicated into the left and right slots.
  function automatic frame_t dup_sample(input sample_t s);
    return {s, s};
  endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider for the I2S transmitter.
// Emits one-cycle strobes on the cycles where BCLK toggles.
module bclk_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bclk,
  output logic fall,
  output logic rise
);

  localparam int            CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          bclk_q;
  logic          bclk_d;
  logic          tc;

  always_comb begin
    tc     = en && (cnt_q == TC);
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (tc) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else if (en) begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;
  assign fall = tc & bclk_q;
  assign rise = tc & ~bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one mono sample per frame, sent in both slots.
// Holds one sample ahead of the serializer; repeats the last on underrun.
module i2s_tx
  import synth_audio_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SDATA,
  output logic                frame_start,
  output logic                underrun
);

  logic    bclk_w;
  logic    fall_w;
  logic    rise_w;

  bitcnt_t bit_cnt_q;
  bitcnt_t bit_cnt_d;
  bitcnt_t bit_cnt_nx;
  logic    lrclk_q;
  logic    lrclk_d;
  frame_t  shreg_q;
  frame_t  shreg_d;
  sample_t hold_q;
  sample_t hold_d;
  logic    hold_valid_q;
  logic    hold_valid_d;
  sample_t last_q;
  sample_t last_d;
  logic    frame_start_q;
  logic    frame_start_d;
  logic    underrun_q;
  logic    underrun_d;
  logic    load;
  logic    xfer;

  bclk_gen #(
    .DIV (BCLK_DIV)
  ) u_bclk (
    .clk  (Clk),
    .rst  (Reset),
    .en   (Enable),
    .bclk (bclk_w),
    .fall (fall_w),
    .rise (rise_w)
  );

  assign bit_cnt_nx = bit_cnt_q + 1'b1;
  // Loading at count 1 gives the I2S one-bit delay after LRCLK.
  assign load       = fall_w && (bit_cnt_nx == BITCNT_W'(1));
  assign xfer       = sample_valid && !hold_valid_q;

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    lrclk_d       = lrclk_q;
    shreg_d       = shreg_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    last_d        = last_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    if (fall_w) begin
      bit_cnt_d = bit_cnt_nx;
      lrclk_d   = bit_cnt_nx[BITCNT_W-1];
      if (load) begin
        frame_start_d = 1'b1;
        if (hold_valid_q) begin
          shreg_d      = dup_sample(hold_q);
          last_d       = hold_q;
          hold_valid_d = 1'b0;
        end else begin
          shreg_d      = dup_sample(last_q);
          underrun_d   = 1'b1;
        end
      end else begin
        shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
      end
    end
    // A transfer only happens with hold empty, so it never races the clear.
    if (xfer) begin
      hold_d       = sample_t'(sample_in);
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bit_cnt_q     <= '0;
      lrclk_q       <= 1'b0;
      shreg_q       <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      last_q        <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      lrclk_q       <= lrclk_d;
      shreg_q       <= shreg_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
      last_q        <= last_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = ~hold_valid_q;
  assign BCLK         = bclk_w;
  assign LRCLK        = lrclk_q;
  assign SDATA        = shreg_q[FRAME_BITS-1];
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

  property p_edges_exclusive;
    @(posedge Clk) disable iff (Reset) !(fall_w && rise_w);
  endproperty
  assert property (p_edges_exclusive);

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at BCLK_DIV = 2.
// Captures each frame off SDATA/LRCLK once per bit slot.
module tb_i2s_tx;

  localparam int          DIV    = 2;
  localparam int          BP     = 2 * DIV;
  localparam logic [31:0] LR_EXP = 32'h0001_FFFE;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] din   = '0;
  logic        ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        fs;
  logic        ur;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  i2s_tx #(
    .BCLK_DIV (DIV)
  ) dut (
    .Clk          (clk),
    .Reset        (rst),
    .Enable       (en),
    .sample_in    (din),
    .sample_valid (valid),
    .sample_ready (ready),
    .BCLK         (bclk),
    .LRCLK        (lrclk),
    .SDATA        (sdata),
    .frame_start  (fs),
    .underrun     (ur)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    din   = v;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 400);
    if (!fs) check("fs_timeout", 32'd0, 32'd1);
  endtask

  // Starts on the negedge right after a load edge.
  task automatic capture(input int pause_at,
                         output logic [31:0] d,
                         output logic [31:0] lr);
    int skip = 0;
    d  = '0;
    lr = '0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) repeat (BP - skip) @(negedge clk);
      skip = 0;
      d  = {d[30:0], sdata};
      lr = {lr[30:0], lrclk};
      if (k == pause_at) begin
        logic b0, l0, s0;
        int   bad = 0;
        repeat (2) @(negedge clk);
        en = 1'b0;
        b0 = bclk;
        l0 = lrclk;
        s0 = sdata;
        for (int i = 0; i < 37; i++) begin
          @(negedge clk);
          if (i == 0) begin
            din   = 16'h12B4;
            valid = 1'b1;
          end
          if (i == 1) begin
            valid = 1'b0;
            check("frz_xfer_rdy", 32'(ready), 32'd0);
          end
          if ({bclk, lrclk, sdata} !== {b0, l0, s0}) bad++;
        end
        en   = 1'b1;
        skip = 2;
        check("frz_stable", 32'(bad), 32'd0);
        check("frz_bclk_hi", 32'(b0), 32'd1);
        check("frz_lr_hi", 32'(l0), 32'd1);
      end
    end
  endtask

  task automatic frame(input string tag,
                       input logic [15:0] v,
                       input int pause_at);
    logic [31:0] d;
    logic [31:0] lr;
    capture(pause_at, d, lr);
    check({tag, "_dat"}, d, {v, v});
    check({tag, "_lr"}, lr, LR_EXP);
  endtask

  task automatic bp_pusher();
    int n = 0;
    din   = 16'h0001;
    valid = 1'b1;
    @(negedge clk);
    din = 16'h0002;
    check("bp_rdy_lo", 32'(ready), 32'd0);
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 300);
    check("bp_rdy_at_fs", 32'(fs), 32'd1);
    check("bp_rdy_wait", 32'(n > 100), 32'd1);
    @(negedge clk);
    valid = 1'b0;
    check("bp_rdy_lo2", 32'(ready), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_bclk", 32'(bclk), 32'd0);
    check("rst_lr", 32'(lrclk), 32'd0);
    check("rst_sd", 32'(sdata), 32'd0);
    check("rst_rdy", 32'(ready), 32'd1);
    check("rst_fs", 32'(fs), 32'd0);
    check("rst_ur", 32'(ur), 32'd0);

    rst   = 1'b0;
    din   = 16'hA5C3;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("f1_rdy_lo", 32'(ready), 32'd0);
    check("f1_bclk_lo", 32'(bclk), 32'd0);
    @(negedge clk);
    check("f1_bclk_rise", 32'(bclk), 32'd1);
    check("f1_fs_c2", 32'(fs), 32'd0);
    @(negedge clk);
    check("f1_fs_c3", 32'(fs), 32'd0);
    @(negedge clk);
    check("f1_fs_c4", 32'(fs), 32'd1);
    check("f1_ur", 32'(ur), 32'd0);
    check("f1_rdy_hi", 32'(ready), 32'd1);
    fork
      frame("f1", 16'hA5C3, -1);
      push(16'h8001);
    join

    wait_frame();
    check("f2_ur", 32'(ur), 32'd0);
    frame("f2", 16'h8001, -1);

    wait_frame();
    check("f3_ur", 32'(ur), 32'd1);
    fork
      bp_pusher();
    join_none
    frame("f3", 16'h8001, -1);

    wait_frame();
    check("f4_ur", 32'(ur), 32'd0);
    frame("f4", 16'h0001, -1);

    wait_frame();
    check("f5_ur", 32'(ur), 32'd0);
    frame("f5", 16'h0002, -1);

    repeat (3) @(negedge clk);
    din   = 16'h7FFF;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("sim_fs", 32'(fs), 32'd1);
    check("sim_ur", 32'(ur), 32'd1);
    check("sim_rdy", 32'(ready), 32'd0);
    frame("f6", 16'h0002, -1);

    wait_frame();
    check("f7_ur", 32'(ur), 32'd0);
    frame("f7", 16'h7FFF, -1);

    wait_frame();
    check("f8_ur", 32'(ur), 32'd1);
    frame("f8", 16'h7FFF, 20);

    wait_frame();
    check("f9_ur", 32'(ur), 32'd0);
    check("f9_msb", 32'(sdata), 32'd0);
    push(16'h5555);
    repeat (33) @(negedge clk);
    check("pre_bclk", 32'(bclk), 32'd1);
    check("pre_sd", 32'(sdata), 32'd1);
    check("pre_rdy", 32'(ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mrst_bclk", 32'(bclk), 32'd0);
    check("mrst_lr", 32'(lrclk), 32'd0);
    check("mrst_sd", 32'(sdata), 32'd0);
    check("mrst_rdy", 32'(ready), 32'd1);
    check("mrst_fs", 32'(fs), 32'd0);
    check("mrst_ur", 32'(ur), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("r2_fs_c3", 32'(fs), 32'd0);
    @(negedge clk);
    check("r2_fs_c4", 32'(fs), 32'd1);
    check("r2_ur", 32'(ur), 32'd1);
    frame("f10", 16'h0000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
